// File: rtl/cache_axi_burst.sv
// rtl/cache_axi_burst.sv - 512-bit cache block refill / write-back over 16-beat AXI4 INCR bursts
// Refill assembles R beats into o_data_block; write-back streams a latched victim block.
module cache_axi_burst #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BLOCK_WIDTH    = 512
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      i_start_read,
  input  logic                      i_start_write,
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  input  logic [BLOCK_WIDTH-1:0]    i_data_block,
  output logic [BLOCK_WIDTH-1:0]    o_data_block,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic                      o_ar_valid,
  input  logic                      i_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0] o_ar_addr,
  output logic                      o_aw_valid,
  input  logic                      i_aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0] o_aw_addr,
  output logic [7:0]                o_ax_len,
  output logic [2:0]                o_ax_size,
  output logic [1:0]                o_ax_burst,
  input  logic                      i_r_valid,
  output logic                      o_r_ready,
  input  logic [AXI_DATA_WIDTH-1:0] i_r_data,
  input  logic                      i_r_last,
  input  logic [1:0]                i_r_resp,
  output logic                      o_w_valid,
  input  logic                      i_w_ready,
  output logic [AXI_DATA_WIDTH-1:0] o_w_data,
  output logic [3:0]                o_w_strb,
  output logic                      o_w_last,
  input  logic                      i_b_valid,
  output logic                      o_b_ready,
  input  logic [1:0]                i_b_resp
);

  localparam int BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFS_W = $clog2(BLOCK_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          beat;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [BLOCK_WIDTH-1:0]    wblk_q;
  logic [BLOCK_WIDTH-1:0]    rblk_q;
  logic                      done_q;
  logic                      error_q;
  logic                      err_pend;

  logic start_wr, start_rd;
  logic ar_hs, aw_hs, r_hs, r_end, w_hs, b_hs;
  logic unused_addr_bits;

  assign unused_addr_bits = ^i_addr[OFS_W-1:0];

  // Write has priority; a simultaneous read request is dropped, not queued.
  assign start_wr = (state == IDLE) && i_start_write;
  assign start_rd = (state == IDLE) && i_start_read && !i_start_write;

  assign ar_hs = (state == RD_ADDR) && i_ar_ready;
  assign aw_hs = (state == WR_ADDR) && i_aw_ready;
  assign r_hs  = (state == RD_DATA) && i_r_valid;
  assign r_end = r_hs && (i_r_last || (beat == LAST_BEAT));
  assign w_hs  = (state == WR_DATA) && i_w_ready;
  assign b_hs  = (state == WR_RESP) && i_b_valid;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_wr)      state_nxt = WR_ADDR;
        else if (start_rd) state_nxt = RD_ADDR;
      end
      RD_ADDR: if (ar_hs) state_nxt = RD_DATA;
      RD_DATA: if (r_end) state_nxt = IDLE;
      WR_ADDR: if (aw_hs) state_nxt = WR_DATA;
      WR_DATA: if (w_hs && (beat == LAST_BEAT)) state_nxt = WR_RESP;
      WR_RESP: if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ar_valid = 1'b0;
    o_aw_valid = 1'b0;
    o_r_ready  = 1'b0;
    o_w_valid  = 1'b0;
    o_b_ready  = 1'b0;
    o_busy     = (state != IDLE);
    case (state)
      RD_ADDR: o_ar_valid = 1'b1;
      RD_DATA: o_r_ready  = 1'b1;
      WR_ADDR: o_aw_valid = 1'b1;
      WR_DATA: o_w_valid  = 1'b1;
      WR_RESP: o_b_ready  = 1'b1;
      default: ;
    endcase
  end

  // Datapath: beat counter, latched request, refill assembly and completion status.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      beat     <= '0;
      addr_q   <= '0;
      wblk_q   <= '0;
      rblk_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      done_q <= r_end || b_hs;
      if (start_wr || start_rd) begin
        addr_q   <= {i_addr[AXI_ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
        beat     <= '0;
        error_q  <= 1'b0;
        err_pend <= 1'b0;
      end
      if (start_wr) wblk_q <= i_data_block;
      if (r_hs) begin
        rblk_q[int'(beat)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_r_data;
        beat <= beat + 1'b1;
        if (i_r_resp != 2'b00) err_pend <= 1'b1;
      end
      // Publish the accumulated status together with the done pulse.
      if (r_end)
        error_q <= err_pend || (i_r_resp != 2'b00) || (i_r_last != (beat == LAST_BEAT));
      if (w_hs) beat <= beat + 1'b1;
      if (b_hs) error_q <= err_pend || (i_b_resp != 2'b00);
    end
  end

  assign o_data_block = rblk_q;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_ar_addr    = addr_q;
  assign o_aw_addr    = addr_q;
  assign o_ax_len     = 8'(BEATS - 1);
  assign o_ax_size    = 3'b010;
  assign o_ax_burst   = 2'b01;
  assign o_w_data     = wblk_q[int'(beat)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign o_w_strb     = 4'hF;
  assign o_w_last     = (state == WR_DATA) && (beat == LAST_BEAT);

endmodule
